// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter
// Hands the Z80 bus from the CPU to one of two bus-master requesters at a time.
// It drives busrq_n toward the CPU and watches busak_n. A tie is resolved
// round-robin. After every release the CPU keeps the bus for MINGAP cycles
// before busrq_n can be asserted again.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   req_i      level request per requester, held for the whole tenure
//   busak_n_i  CPU bus acknowledge (same clock domain)
//   busrq_n_o  registered bus request to the CPU
//   gnt_o      registered one-hot grant
//   busy_o     high whenever the FSM is not in IDLE
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | CPU owns the bus, no request pending
// WAIT_ACK  | busrq_n asserted for the selected requester, waiting busak_n
// GRANT     | selected requester owns the bus
// RELEASE   | grant dropped, waiting for the CPU to take the bus back
// GAP       | CPU-owned guard interval of MINGAP cycles
module bus_master_arbiter #(
    parameter int unsigned MINGAP = 4,
    parameter int unsigned GAPW   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       busak_n_i,
    output logic       busrq_n_o,
    output logic [1:0] gnt_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_GRANT,
        S_RELEASE,
        S_GAP
    } state_t;

    localparam logic [GAPW-1:0] GAP_LOAD = GAPW'(MINGAP);

    state_t          state_q, state_d;
    logic            sel_q, sel_d;
    logic            last_q, last_d;
    logic            busrq_n_q, busrq_n_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [GAPW-1:0] gap_q, gap_d;
    logic            req_sel;

    assign req_sel = req_i[sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            busrq_n_q <= 1'b1;
            gnt_q     <= 2'b00;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            busrq_n_q <= busrq_n_d;
            gnt_q     <= gnt_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        busrq_n_d = busrq_n_q;
        gnt_d     = gnt_q;
        gap_d     = gap_q;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    // single request: req_i[1] is the index; tie: favour the one not served last
                    sel_d     = (req_i == 2'b11) ? ~last_q : req_i[1];
                    busrq_n_d = 1'b0;
                    state_d   = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!req_sel) begin
                    busrq_n_d = 1'b1;
                    state_d   = S_RELEASE;
                end else if (!busak_n_i) begin
                    gnt_d   = sel_q ? 2'b10 : 2'b01;
                    last_d  = sel_q;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req_sel) begin
                    gnt_d     = 2'b00;
                    busrq_n_d = 1'b1;
                    state_d   = S_RELEASE;
                end else if (busak_n_i) begin
                    // CPU took the bus back under us: stop driving, but keep
                    // busrq_n low until the requester lets go
                    gnt_d   = 2'b00;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!req_sel) begin
                    busrq_n_d = 1'b1;
                end
                // only leave once our own request is withdrawn and the CPU has the bus
                if (busak_n_i && busrq_n_q) begin
                    if (GAP_LOAD == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q <= 1) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o    = (state_q != S_IDLE);
        busrq_n_o = busrq_n_q;
        gnt_o     = gnt_q;
    end

endmodule

// File: tb/tb_bus_master_arbiter.sv
module tb_bus_master_arbiter;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic       busak_n = 1'b1;
    logic       busrq_n;
    logic [1:0] gnt;
    logic       busy;

    logic [1:0] req0 = 2'b00;
    logic       busak0_n = 1'b1;
    logic       busrq0_n;
    logic [1:0] gnt0;
    logic       busy0;

    int   cyc = 0;
    logic bk_q = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic [1:0] g;
        int         c;
    } exp_t;
    exp_t exp_q[$];

    bus_master_arbiter #(.MINGAP(GAP), .GAPW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .busak_n_i(busak_n),
        .busrq_n_o(busrq_n), .gnt_o(gnt), .busy_o(busy)
    );

    bus_master_arbiter #(.MINGAP(0), .GAPW(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .busak_n_i(busak0_n),
        .busrq_n_o(busrq0_n), .gnt_o(gnt0), .busy_o(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        bk_q <= busak_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every change of gnt is matched against the next expected grant event.
    initial begin
        logic [1:0] prev;
        exp_t       e;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (gnt !== prev) begin
                chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
                if (gnt != 2'b00) chk("gnt_after_ack", bk_q, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL gnt_unexpected: got %b expected no change from %b (cycle %0d)", gnt, prev, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt_value", gnt, e.g);
                    chk("gnt_cycle", cyc, e.c);
                end
                prev = gnt;
            end
        end
    end

    // One complete tenure for grant g, starting from wherever busrq_n is (or will go) low.
    task automatic run_tenure(input logic [1:0] g, input int ack_dly, input int hold, input bit reraise);
        int n;
        n = 0;
        while (busrq_n !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk("busrq_timeout", busrq_n, 0);
        repeat (ack_dly) tick();
        busak_n = 1'b0;
        exp_q.push_back('{g, cyc + 1});
        tick();
        chk("busrq_hold", busrq_n, 0);
        repeat (hold) tick();
        req = req & ~g;
        exp_q.push_back('{2'b00, cyc + 1});
        tick();
        chk("rel_busrq", busrq_n, 1);
        busak_n = 1'b1;
        if (reraise) req = req | g;
        repeat (GAP) tick();
        chk("gap_busy", busy, 1);
        chk("gap_busrq", busrq_n, 1);
        tick();
        chk("gap_end_idle", busy, 0);
        if (req != 2'b00) begin
            tick();
            chk("turnaround", busrq_n, 0);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busrq", busrq_n, 1);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // single request, CPU acks 3 clk after busrq_n falls
        req = 2'b01;
        tick();
        chk("req_to_busrq", busrq_n, 0);
        chk("busy_wait", busy, 1);
        run_tenure(2'b01, 3, 2, 1'b0);

        // tie held: last=0, so grants go 10, 01, 10, 01
        req = 2'b11;
        run_tenure(2'b10, 0, 2, 1'b1);
        run_tenure(2'b01, 1, 1, 1'b1);
        run_tenure(2'b10, 2, 1, 1'b0);
        run_tenure(2'b01, 0, 1, 1'b0);

        // withdrawal of requester 1 before ack: last must stay 0
        req = 2'b10;
        tick();
        chk("wd_busrq_low", busrq_n, 0);
        req = 2'b00;
        tick();
        chk("wd_busrq_rel", busrq_n, 1);
        chk("wd_busy", busy, 1);
        repeat (GAP) tick();
        chk("wd_gap_busy", busy, 1);
        tick();
        chk("wd_idle", busy, 0);
        req = 2'b11;
        run_tenure(2'b10, 1, 1, 1'b0);

        // spurious ack loss; WAIT_ACK for requester 0 already under way
        busak_n = 1'b0;
        exp_q.push_back('{2'b01, cyc + 1});
        tick();
        busak_n = 1'b1;
        exp_q.push_back('{2'b00, cyc + 1});
        tick();
        chk("spur_busrq_hold", busrq_n, 0);
        chk("spur_busy", busy, 1);
        tick();
        chk("spur_busrq_hold2", busrq_n, 0);
        req = 2'b00;
        tick();
        chk("spur_busrq_rel", busrq_n, 1);
        repeat (GAP) tick();
        chk("spur_gap_busy", busy, 1);
        tick();
        chk("spur_idle", busy, 0);

        // async reset mid-GRANT (last=0 before reset)
        req = 2'b01;
        tick();
        busak_n = 1'b0;
        exp_q.push_back('{2'b01, cyc + 1});
        tick();
        tick();
        rst_n = 1'b0;
        exp_q.push_back('{2'b00, cyc});
        #1;
        chk("arst_busrq", busrq_n, 1);
        chk("arst_gnt", gnt, 0);
        chk("arst_busy", busy, 0);
        req = 2'b11;
        busak_n = 1'b1;
        tick();
        rst_n = 1'b1;
        run_tenure(2'b01, 1, 1, 1'b0);
        run_tenure(2'b10, 1, 1, 1'b0);

        // MINGAP=0 instance
        req0 = 2'b10;
        tick();
        chk("m0_busrq", busrq0_n, 0);
        busak0_n = 1'b0;
        tick();
        chk("m0_gnt", gnt0, 2'b10);
        req0 = 2'b00;
        tick();
        chk("m0_rel_busrq", busrq0_n, 1);
        chk("m0_rel_gnt", gnt0, 2'b00);
        req0 = 2'b10;
        busak0_n = 1'b1;
        tick();
        chk("m0_idle_busrq", busrq0_n, 1);
        tick();
        chk("m0_reassert", busrq0_n, 0);
        busak0_n = 1'b0;
        tick();
        chk("m0_gnt2", gnt0, 2'b10);
        req0 = 2'b00;
        tick();
        busak0_n = 1'b1;
        tick();
        tick();
        chk("m0_idle", busy0, 0);

        tick();
        tick();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
